// File: rtl/sdram_ch_writer_pkg.sv
// sdram_ch_writer_pkg: shared types, constants and width helpers for the SDRAM channel writer
package sdram_ch_writer_pkg;
  typedef enum logic {IDLE, WRITE} state_t;
  localparam int SAMPLE_W = 16;
  localparam logic [1:0] BE_ALL = 2'b11;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic int ch_w(input int n_ch);
    return clog2(n_ch) < 1 ? 1 : clog2(n_ch);
  endfunction
endpackage

// File: rtl/sdram_ch_writer_if.sv
// sdram_ch_writer_if: sample-stream and Avalon-MM write signals of the SDRAM channel writer
interface sdram_ch_writer_if
  import sdram_ch_writer_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int AVM_AW = 24
);
  logic                     enable;
  logic                     clear;
  logic [N_CH-1:0]          ch_valid;
  logic [N_CH*SAMPLE_W-1:0] ch_data;
  logic [N_CH-1:0]          ch_ready;
  logic [AVM_AW-1:0]        avm_address;
  logic [SAMPLE_W-1:0]      avm_writedata;
  logic [1:0]               avm_byteenable;
  logic                     avm_write;
  logic                     avm_waitrequest;
  logic                     busy;
  logic [N_CH-1:0]          wrapped;
  logic                     stall_err;
  modport master (
    input  enable, clear, ch_valid, ch_data, avm_waitrequest,
    output ch_ready, avm_address, avm_writedata, avm_byteenable, avm_write, busy, wrapped, stall_err
  );
  modport slave (
    output enable, clear, ch_valid, ch_data, avm_waitrequest,
    input  ch_ready, avm_address, avm_writedata, avm_byteenable, avm_write, busy, wrapped, stall_err
  );
endinterface

// File: rtl/sdram_ch_writer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after the last grant
module rr_arbiter
  import sdram_ch_writer_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_last,
  output logic [N_CH-1:0] o_grant,
  output logic [CH_W-1:0] o_idx,
  output logic            o_any
);
  int w_c;
  // scan farthest-first so the nearest request after i_last is the one that sticks
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_c     = 0;
    for (int k = N_CH; k >= 1; k--) begin
      w_c = (int'(i_last) + k) % N_CH;
      if (i_req[w_c]) begin
        o_grant      = '0;
        o_grant[w_c] = 1'b1;
        o_idx        = CH_W'(w_c);
        o_any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sdram_ch_writer.sv
// sdram_ch_writer: round-robin writer of N_CH sample streams into per-channel SDRAM rings; SDRAM_CH_WRITER_STALL_TO_EN adds a waitrequest timeout
module sdram_ch_writer
  import sdram_ch_writer_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int AVM_AW    = 24,
  parameter int RING_AW   = 20,
  parameter int STALL_MAX = 1023
) (
  input logic clk,
  input logic reset,
  sdram_ch_writer_if.master bus
);
  localparam int CH_W = ch_w(N_CH);
  state_t              r_state;
  logic [CH_W-1:0]     r_last;
  logic [CH_W-1:0]     r_g;
  logic [RING_AW-1:0]  r_ptr [N_CH];
  logic [N_CH-1:0]     r_wrapped;
  logic                r_clr_pend;
  logic                r_write;
  logic [AVM_AW-1:0]   r_addr;
  logic [SAMPLE_W-1:0] r_data;
  logic [N_CH-1:0]     w_grant;
  logic [CH_W-1:0]     w_idx;
  logic                w_any;
  logic                w_accept;
  logic                w_abort;
  logic                w_clr_now;
  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .i_req   (bus.ch_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );
  assign w_accept           = r_state == IDLE && bus.enable && !bus.clear && w_any;
  assign w_clr_now          = r_clr_pend || bus.clear;
  assign bus.ch_ready       = w_accept ? w_grant : '0;
  assign bus.avm_address    = r_addr;
  assign bus.avm_writedata  = r_data;
  assign bus.avm_byteenable = BE_ALL;
  assign bus.avm_write      = r_write;
  assign bus.busy           = r_state == WRITE;
  assign bus.wrapped        = r_wrapped;
`ifdef SDRAM_CH_WRITER_STALL_TO_EN
  logic [31:0] r_cnt;
  logic        r_err;
  assign w_abort       = bus.avm_waitrequest && r_cnt == 32'(STALL_MAX - 1);
  assign bus.stall_err = r_err;
`else
  assign w_abort       = 1'b0;
  assign bus.stall_err = 1'b0;
`endif
  // grant/issue in IDLE, hold the write until the slave takes it (or times out), then advance the ring
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= CH_W'(N_CH - 1);
      r_g        <= '0;
      r_wrapped  <= '0;
      r_clr_pend <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      for (int i = 0; i < N_CH; i++) r_ptr[i] <= '0;
`ifdef SDRAM_CH_WRITER_STALL_TO_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else if (r_state == IDLE) begin
      if (bus.clear) begin
        for (int i = 0; i < N_CH; i++) r_ptr[i] <= '0;
        r_wrapped <= '0;
`ifdef SDRAM_CH_WRITER_STALL_TO_EN
        r_err     <= 1'b0;
`endif
      end else if (w_accept) begin
        r_g     <= w_idx;
        r_addr  <= AVM_AW'({w_idx, r_ptr[w_idx]});
        r_data  <= bus.ch_data[SAMPLE_W*w_idx +: SAMPLE_W];
        r_write <= 1'b1;
        r_state <= WRITE;
      end
    end else begin
      if (bus.clear) r_clr_pend <= 1'b1;
      if (!bus.avm_waitrequest || w_abort) begin
        r_write    <= 1'b0;
        r_state    <= IDLE;
        r_last     <= r_g;
        r_clr_pend <= 1'b0;
        if (w_clr_now) begin
          for (int i = 0; i < N_CH; i++) r_ptr[i] <= '0;
          r_wrapped <= '0;
        end else if (!w_abort) begin
          r_ptr[r_g] <= r_ptr[r_g] + 1'b1;
          if (&r_ptr[r_g]) r_wrapped[r_g] <= 1'b1;
        end
`ifdef SDRAM_CH_WRITER_STALL_TO_EN
        r_cnt <= '0;
        if (w_abort || w_clr_now) r_err <= w_abort;
`endif
      end
`ifdef SDRAM_CH_WRITER_STALL_TO_EN
      else r_cnt <= r_cnt + 1'b1;
`endif
    end
endmodule

// File: tb/tb_sdram_ch_writer.sv
// tb_sdram_ch_writer: table vectors, directed corner sequences and randomized traffic against a reference model
module tb_sdram_ch_writer;
  import sdram_ch_writer_pkg::*;
  localparam int N = 4, AW = 24, RA = 4, SMAX = 8, RING = 1 << RA;
  logic clk = 1'b0, reset = 1'b1;
  sdram_ch_writer_if #(.N_CH(N), .AVM_AW(AW)) bus ();
  sdram_ch_writer #(.N_CH(N), .AVM_AW(AW), .RING_AW(RA), .STALL_MAX(SMAX)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int m_ptr [N];
  logic [N-1:0] m_wrap;
  int m_last, m_g, m_scnt;
  logic m_busy, m_clrp, m_err;
  logic [31:0] m_addr;
  logic [15:0] m_data;
  int grants[$];

  typedef struct {
    logic en; logic clr; logic [3:0] v; logic w;
    logic [3:0] rdy; logic wr; logic [23:0] addr; logic [15:0] data;
  } vec_t;
  vec_t tv [17];
  localparam logic [63:0] TD = 64'hD3D3_A5A5_B1B1_C0C0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < N; i++) m_ptr[i] = 0;
    m_wrap = '0;
    m_err = 1'b0;
  endtask

  task automatic model_done(input logic abort);
    m_busy = 1'b0;
    m_last = m_g;
    m_scnt = 0;
    if (m_clrp) model_zero();
    else if (!abort) begin
      if (m_ptr[m_g] == RING - 1) m_wrap[m_g] = 1'b1;
      m_ptr[m_g] = (m_ptr[m_g] + 1) % RING;
    end
    if (abort) m_err = 1'b1;
    m_clrp = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0; bus.clear = 1'b0; bus.ch_valid = '0; bus.ch_data = '0; bus.avm_waitrequest = 1'b0;
    #1;
    chk("rst_write", 32'(bus.avm_write), 32'd0);
    chk("rst_addr", 32'(bus.avm_address), 32'd0);
    chk("rst_data", 32'(bus.avm_writedata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wrapped", 32'(bus.wrapped), 32'd0);
    chk("rst_stall_err", 32'(bus.stall_err), 32'd0);
    chk("rst_ready", 32'(bus.ch_ready), 32'd0);
    chk("byteenable", 32'(bus.avm_byteenable), 32'd3);
    @(posedge clk); #1;
    reset = 1'b0;
    model_zero();
    m_last = N - 1; m_busy = 1'b0; m_clrp = 1'b0; m_scnt = 0; m_g = 0;
  endtask

  task automatic cyc(input logic en, input logic clr, input logic [N-1:0] v, input logic [63:0] d, input logic w);
    int g;
    logic [N-1:0] er;
    bus.enable = en; bus.clear = clr; bus.ch_valid = v; bus.ch_data = d; bus.avm_waitrequest = w;
    #1;
    g = rr(v);
    er = (!m_busy && en && !clr && g >= 0) ? N'(1) << g : '0;
    chk("ch_ready", 32'(bus.ch_ready), 32'(er));
    chk("avm_write", 32'(bus.avm_write), 32'(m_busy));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("wrapped", 32'(bus.wrapped), 32'(m_wrap));
    chk("stall_err", 32'(bus.stall_err), 32'(m_err));
    if (m_busy) begin
      chk("avm_address", 32'(bus.avm_address), m_addr);
      chk("avm_writedata", 32'(bus.avm_writedata), 32'(m_data));
    end
    if (bus.ch_ready != '0) grants.push_back($clog2(bus.ch_ready));
    if (!m_busy) begin
      if (clr) model_zero();
      else if (er != '0) begin
        m_g = g;
        m_addr = 32'(g * RING + m_ptr[g]);
        m_data = d[16*g +: 16];
        m_busy = 1'b1;
      end
    end else begin
      if (clr) m_clrp = 1'b1;
      if (!w) model_done(1'b0);
`ifdef SDRAM_CH_WRITER_STALL_TO_EN
      else begin
        m_scnt++;
        if (m_scnt == SMAX) model_done(1'b1);
      end
`endif
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, 24'h0,  16'h0};
    tv[1]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 24'h20, 16'hA5A5};
    tv[2]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0, 24'h0,  16'h0};
    for (int i = 3; i <= 7; i++) tv[i] = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 24'h30, 16'hD3D3};
    tv[8]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 24'h30, 16'hD3D3};
    tv[9]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 24'h0,  16'h0};
    tv[10] = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 24'h00, 16'hC0C0};
    tv[11] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 24'h0,  16'h0};
    tv[12] = '{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 24'h0,  16'h0};
    tv[13] = '{1'b1, 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 24'h0,  16'h0};
    tv[14] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 24'h10, 16'hB1B1};
    tv[15] = '{1'b1, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, 24'h0,  16'h0};
    tv[16] = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 24'h20, 16'hA5A5};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.enable = tv[i].en; bus.clear = tv[i].clr; bus.ch_valid = tv[i].v;
      bus.ch_data = TD; bus.avm_waitrequest = tv[i].w;
      #1;
      chk($sformatf("tv%0d_ready", i), 32'(bus.ch_ready), 32'(tv[i].rdy));
      chk($sformatf("tv%0d_write", i), 32'(bus.avm_write), 32'(tv[i].wr));
      chk($sformatf("tv%0d_busy", i), 32'(bus.busy), 32'(tv[i].wr));
      if (tv[i].wr) begin
        chk($sformatf("tv%0d_addr", i), 32'(bus.avm_address), 32'(tv[i].addr));
        chk($sformatf("tv%0d_data", i), 32'(bus.avm_writedata), 32'(tv[i].data));
      end
      @(posedge clk); #1;
    end

    do_reset();
    cyc(1'b1, 1'b0, 4'b0001, TD, 1'b1);
    cyc(1'b1, 1'b0, 4'b0000, TD, 1'b1);
    do_reset();

    grants.delete();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'b1111, {$urandom, $urandom}, 1'b0);
    chk("rr_count", 32'(grants.size()), 32'd8);
    for (int i = 0; i < grants.size() && i < 8; i++) chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 4));
    for (int i = 0; i < 4; i++) chk($sformatf("rr_ptr%0d", i), 32'(m_ptr[i]), 32'd2);

    do_reset();
    for (int s = 0; s < 17; s++) begin
      cyc(1'b1, 1'b0, 4'b0001, {$urandom, $urandom}, 1'b0);
      chk($sformatf("wrap_addr%0d", s), 32'(bus.avm_address), 32'(s % RING));
      cyc(1'b1, 1'b0, 4'b0000, 64'h0, 1'b0);
      if (s == 14) chk("wrapped_before_16", 32'(bus.wrapped), 32'd0);
      if (s == 15) chk("wrapped_after_16", 32'(bus.wrapped), 32'b0001);
    end

    for (int s = 0; s < 7; s++) begin
      cyc(1'b1, 1'b0, 4'b0010, {$urandom, $urandom}, 1'b0);
      cyc(1'b1, 1'b0, 4'b0000, 64'h0, 1'b0);
    end
    cyc(1'b1, 1'b0, 4'b0010, {$urandom, $urandom}, 1'b1);
    chk("clrw_addr_before", 32'(bus.avm_address), 32'h17);
    cyc(1'b1, 1'b1, 4'b0000, 64'h0, 1'b1);
    cyc(1'b1, 1'b0, 4'b0010, 64'h0, 1'b1);
    cyc(1'b1, 1'b0, 4'b0010, 64'h0, 1'b0);
    chk("clrw_wrapped", 32'(bus.wrapped), 32'd0);
    cyc(1'b1, 1'b0, 4'b0010, {$urandom, $urandom}, 1'b0);
    chk("clrw_addr_after", 32'(bus.avm_address), 32'h10);
    cyc(1'b1, 1'b0, 4'b0000, 64'h0, 1'b0);

`ifdef SDRAM_CH_WRITER_STALL_TO_EN
    do_reset();
    cyc(1'b1, 1'b0, 4'b0011, TD, 1'b1);
    for (int i = 0; i < SMAX; i++) cyc(1'b1, 1'b0, 4'b0000, TD, 1'b1);
    chk("to_write_dropped", 32'(bus.avm_write), 32'd0);
    chk("to_stall_err", 32'(bus.stall_err), 32'd1);
    grants.delete();
    cyc(1'b1, 1'b0, 4'b0011, TD, 1'b0);
    chk("to_next_grant", grants.size() > 0 ? 32'(grants[0]) : 32'hFFFF_FFFF, 32'd1);
    cyc(1'b1, 1'b0, 4'b0000, TD, 1'b0);
    chk("to_ptr_held", 32'(bus.avm_address), 32'h10);
`endif

    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, 4'($urandom_range(0, 15)),
          {$urandom, $urandom}, $urandom_range(0, 9) < 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_ch_writer.md
Name: sdram_ch_writer

Overview:
- Round-robin write scheduler that shares the single 16-bit SDRAM controller Avalon-MM slave between N_CH ADC sample streams (one per hydrophone).
- Each channel gets its own ring region in SDRAM. The block sequences one Avalon write per accepted sample and tracks per-channel write pointers and wrap flags.
- Sits between the per-channel ADC sample FIFOs and the sdram controller's s1 port.

Parameters:
- N_CH, 4, number of sample channels (2..8).
- AVM_AW, 24, Avalon word-address width of the SDRAM controller.
- RING_AW, 20, log2 of ring size in 16-bit words per channel; requires RING_AW + clog2(N_CH) <= AVM_AW.
- STALL_MAX, 1023, waitrequest timeout in cycles (optional feature only).

Ports:
- clk, in, 1, system clock (same domain as the SDRAM controller).
- reset, in, 1, asynchronous, active-high.
- enable, in, 1, capture arm; when low, no new samples are accepted.
- clear, in, 1, pulse: zero all pointers and wrap flags.
- ch_valid, in, N_CH, per-channel sample valid.
- ch_data, in, N_CH*16, channel i sample at bits [16i+15:16i].
- ch_ready, out, N_CH, per-channel accept (one-hot or zero).
- avm_address, out, AVM_AW, word address.
- avm_writedata, out, 16, write data.
- avm_byteenable, out, 2, tied to 2'b11.
- avm_write, out, 1, write request.
- avm_waitrequest, in, 1, slave stall.
- busy, out, 1, high in WRITE state.
- wrapped, out, N_CH, sticky: channel ring has wrapped at least once.
- stall_err, out, 1, sticky timeout flag (optional feature; tied 0 otherwise).

Behaviour:
- Reset (async): state=IDLE; ch_ready=0; avm_write=0; avm_address=0; avm_writedata=0; busy=0; wrapped=0; stall_err=0; all ptr[i]=0; last_grant=N_CH-1, so ch0 wins first.
- ch_ready is combinational from state/enable/valid/grant. All other outputs are registered.
- IDLE state:
  - If enable=1 and |ch_valid: grant g = first valid channel searching last_grant+1, +2, … modulo N_CH.
  - ch_ready[g]=1 in that same cycle; the sample transfers on ch_valid[g]&ch_ready[g].
  - Next edge: avm_writedata<=ch_data[g]; avm_address<={zero-pad, g[CH_W-1:0], ptr[g]}; avm_write<=1; go WRITE.
- WRITE state:
  - avm_write, address and data are held stable while avm_waitrequest=1. ch_ready=0.
  - On the first cycle with waitrequest=0, the write completes. Next edge: avm_write<=0; ptr[g]<=ptr[g]+1 mod 2^RING_AW; if ptr[g] was all-ones, wrapped[g]<=1; last_grant<=g; go IDLE.
- Throughput: at most one sample per 2 cycles. Latency from accept to avm_write high is 1 cycle.
- Fairness: with all channels continuously valid, grants run 0,1,2,3,0,… Each channel waits at most N_CH-1 writes.
- enable falling mid-WRITE: the current write completes; no new grants follow.
- clear:
  - In IDLE: zeroes ptr/wrapped on the next edge. No grant is issued in the clear cycle.
  - In WRITE: latched as pending and applied on the completion edge, overriding the increment. Pending clear wins over wrap.
- A reset asserted mid-WRITE drops avm_write immediately (async). The in-flight sample is lost; this is accepted.
- ch_valid deasserting while not granted is legal and has no effect.

Optional Feature:
- Macro: SDRAM_CH_WRITER_STALL_TO_EN.
- Defined: a counter runs while in WRITE with waitrequest=1. When it reaches STALL_MAX:
  - abort: avm_write<=0, state=IDLE, stall_err<=1 (sticky until reset or clear);
  - the pointer does not advance; last_grant<=g.
- Undefined: no counter; the block waits indefinitely on waitrequest; stall_err is tied to 0.

Decomposition:
- Package sdram_ch_writer_pkg holds:
  - state typedef {IDLE, WRITE};
  - SAMPLE_W=16 and BE_ALL=2'b11;
  - a clog2 helper and the CH_W derivation.
- One sub-module: rr_arbiter (N_CH requests, last_grant in, one-hot grant plus index out; combinational rotate-priority search).

Test Plan:
- Single sample: enable=1, ch2 valid with 16'hA5A5, waitrequest=0 → ch_ready[2] for 1 cycle; next cycle avm_write=1, addr={2,20'h0}, data=A5A5; after completion ptr[2]=1.
- Round robin: all 4 channels valid continuously, no stall, 8 samples → grant order 0,1,2,3,0,1,2,3; each ptr=2.
- Waitrequest stall: hold waitrequest=1 for 5 cycles → addr and data stable for 6 cycles, exactly one ptr increment, no ch_ready during the stall.
- Wrap: RING_AW=4, ch0 writes 17 samples → 17th address={0,4'h0}; wrapped[0]=1 after the 16th; other wrapped bits stay 0.
- clear during WRITE: clear pulse while waitrequest=1 at ptr[1]=7 → after completion ptr[1]=0 and wrapped=0.
- (STALL_TO_EN, STALL_MAX=8) waitrequest held high → avm_write drops after 8 stall cycles, stall_err=1, ptr unchanged, next grant goes to the next valid channel.
